// File: rtl/sm_pipe_ctrl.sv
// rtl/sm_pipe_ctrl.sv - hazard resolution and pipeline register control for the 5-stage core
module sm_pipe_ctrl #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_ack,
  input  logic                  m_mem_req,
  input  logic                  dmem_ack,
  input  logic                  de_mem_read,
  input  logic [REG_ADDR_W-1:0] de_rd,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  e_branch_taken,
  output logic                  dmem_req,
  output logic                  pc_we,
  output logic                  fd_we,
  output logic                  fd_clr_n,
  output logic                  de_we,
  output logic                  de_clr_n,
  output logic                  em_we,
  output logic                  em_clr_n,
  output logic                  mw_we,
  output logic                  mw_clr_n,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [7:0] TOUT_VAL = 8'(DMEM_TIMEOUT - 1);

  logic       kill_fetch;
  logic       kill_fetch_nxt;
  logic [7:0] wcnt;
  logic       dwait;
  logic       tout;
  logic       dstall;
  logic       lu;
  logic       istall;

  assign dmem_req = m_mem_req;
  assign dwait    = m_mem_req & ~dmem_ack;
  assign tout     = (wcnt == TOUT_VAL);
  // On the timeout cycle the access is released even without an ack.
  assign dstall   = dwait & ~tout;
  assign lu       = de_mem_read & (de_rd != '0) & ((de_rd == fd_rs) | (de_rd == fd_rt));
  // A killed fetch makes the next returning word look like a fetch miss.
  assign istall   = ~imem_ack | kill_fetch;

  // Prioritised stage controls and next value of the fetch-kill flag.
  always_comb begin
    pc_we          = 1'b1;
    fd_we          = 1'b1;
    fd_clr_n       = 1'b1;
    de_we          = 1'b1;
    de_clr_n       = 1'b1;
    em_we          = 1'b1;
    em_clr_n       = 1'b1;
    mw_we          = 1'b1;
    mw_clr_n       = 1'b1;
    kill_fetch_nxt = kill_fetch;
    if (dstall) begin
      // Freeze everything up to M; W receives a bubble. Branch waits in E.
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      de_we    = 1'b0;
      em_we    = 1'b0;
      mw_clr_n = 1'b0;
    end else if (e_branch_taken) begin
      fd_clr_n       = 1'b0;
      de_clr_n       = 1'b0;
      // A fetch still outstanding for the wrong path must be discarded.
      kill_fetch_nxt = ~imem_ack;
    end else begin
      if (imem_ack) begin
        kill_fetch_nxt = 1'b0;
      end
      if (lu) begin
        // Holding D (instead of bubbling it) keeps the instruction alive
        // even when a fetch stall coincides.
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        de_clr_n = 1'b0;
      end else if (istall) begin
        pc_we    = 1'b0;
        fd_clr_n = 1'b0;
      end
    end
  end

  // State: fetch-kill flag, data-wait counter, sticky bus error, stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_fetch <= 1'b0;
      wcnt       <= 8'd0;
      bus_err    <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      kill_fetch <= kill_fetch_nxt;
      wcnt       <= dstall ? (wcnt + 8'd1) : 8'd0;
      if (dwait && tout) begin
        bus_err <= 1'b1;
      end
      if (!pc_we) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/sm_pipe_ctrl.md
Name: sm_pipe_ctrl

Overview:
Pipeline control stage for the 5-stage core (F, D, E, M, W). It generates the write-enable and synchronous-clear controls consumed by the clearable/enable pipeline registers at the PC and the FD, DE, EM and MW boundaries. It resolves these hazards:
- data-memory wait with timeout
- instruction-memory wait
- load-use hazard
- taken-branch flush, including killing an in-flight fetch

It also provides a stall-cycle performance counter and a sticky data-bus error flag.

Parameters:
DMEM_TIMEOUT, 16, cycles of data-memory wait before the access is aborted; valid range 2..255
REG_ADDR_W, 5, register-file address width
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
imem_ack  in  1  instruction word valid for the current PC this cycle
m_mem_req  in  1  instruction in M is a load or store
dmem_ack  in  1  data memory completes the M access this cycle
de_mem_read  in  1  instruction in E (DE register output) is a load
de_rd  in  REG_ADDR_W  destination register of the instruction in E
fd_rs  in  REG_ADDR_W  rs of the instruction in D
fd_rt  in  REG_ADDR_W  rt of the instruction in D
e_branch_taken  in  1  branch/jump in E resolved taken
dmem_req  out  1  data-memory request; equals m_mem_req
pc_we  out  1  PC register enable
fd_we, fd_clr_n  out  1 each  FD register enable and clear (clear active-low)
de_we, de_clr_n  out  1 each  DE register enable and clear
em_we, em_clr_n  out  1 each  EM register enable and clear
mw_we, mw_clr_n  out  1 each  MW register enable and clear
bus_err  out  1  sticky: a data-memory access timed out
stall_cnt  out  CNT_W  count of cycles with pc_we=0; wraps modulo 2^CNT_W

Behaviour:
- Sequential state:
  - kill_fetch (1 bit)
  - wcnt (8 bits), the data-wait counter
  - bus_err
  - stall_cnt
- Reset values: all state is 0. Consequently dmem_req follows m_mem_req. All other outputs are combinational functions of state and inputs.
- A register bubble is we=1 with clr_n=0. A hold is we=0; clr_n is then don't-care and is driven 1.
- Derived signals:
  - tout = (wcnt == DMEM_TIMEOUT-1)
  - dstall = m_mem_req & ~dmem_ack & ~tout
  - lu = de_mem_read & (de_rd != 0) & (de_rd == fd_rs | de_rd == fd_rt)
  - istall = ~imem_ack | kill_fetch
- Control cases, highest priority first:
  1. dstall:
     - PC, FD, DE and EM hold.
     - MW gets a bubble.
     - e_branch_taken is ignored; the branch stays in E and reasserts after the stall.
  2. e_branch_taken:
     - pc_we=1 (loads the target).
     - FD and DE get bubbles.
     - EM and MW advance.
     - If imem_ack=0 this cycle, kill_fetch is set to 1.
  3. lu:
     - PC and FD hold.
     - DE gets a bubble.
     - EM and MW advance.
  4. istall:
     - pc_we=0.
     - FD gets a bubble.
     - DE, EM and MW advance.
  5. Otherwise: all we=1 and all clr_n=1.
- kill_fetch:
  - While kill_fetch=1, istall is forced to 1, so the returning stale word is discarded into an FD bubble and the PC keeps the target.
  - kill_fetch clears on the first cycle with imem_ack=1 that is not in case 1.
  - The target is refetched on the following cycle.
- wcnt:
  - Increments each cycle that m_mem_req & ~dmem_ack holds.
  - Resets to 0 on any cycle where that condition is false, and on the tout cycle.
- Timeout:
  - On tout with ~dmem_ack, the access is treated as complete: EM and MW advance, and the load data is whatever the bus presents.
  - bus_err is set and held until reset.
- Simultaneous events:
  - dmem_ack and tout in the same cycle is a normal completion and does not set bus_err.
  - lu together with istall: lu wins, so D is held rather than bubbled and no instruction is lost.
- stall_cnt increments on every cycle with pc_we=0 and wraps to 0 past all-ones.
- Reset mid-operation: rst_n low clears kill_fetch, wcnt, bus_err and stall_cnt immediately (asynchronous). Outputs then reflect case 5 or the current inputs. No pending redirect survives reset.
- Latency: all controls are combinational in the same cycle as the hazard; state updates take effect on the next edge.

Test Plan:
- Load-use: de_mem_read=1, de_rd=8, fd_rs=8 for one cycle -> pc_we=0, fd_we=0, de_we=1, de_clr_n=0, em_we=mw_we=1; stall_cnt 0->1. With de_rd=0 instead -> no stall.
- Data wait: m_mem_req=1, dmem_ack held low 3 cycles then high -> for 3 cycles pc_we=fd_we=de_we=em_we=0 and mw_we=1, mw_clr_n=0; on the ack cycle all we=1; stall_cnt=3; bus_err=0.
- Timeout with DMEM_TIMEOUT=4: m_mem_req=1, dmem_ack stuck low -> 3 stall cycles, then on the 4th cycle em_we=mw_we=1 with clr_n=1; bus_err=1 and stays 1 after m_mem_req drops; wcnt returns to 0.
- Branch during fetch wait: imem_ack=0 with e_branch_taken=1 -> pc_we=1, fd_clr_n=0, de_clr_n=0, kill_fetch=1. Next cycle imem_ack=1 -> pc_we=0, FD bubble, kill_fetch=0. The cycle after, normal fetch with all we=1.
- Branch during data stall: dstall active with e_branch_taken=1 -> no flush and pc_we=0. After dmem_ack, with the branch still asserted -> FD and DE bubbles, pc_we=1.
- Async reset: assert rst_n=0 mid data-wait with kill_fetch=1 and stall_cnt=5 -> kill_fetch, wcnt, bus_err and stall_cnt read 0 immediately, without a clock edge.
